alu_seq_n: RTL

Parametrised, sequential successor to the team's 4-bit combinational ALU. It keeps the same ten opcodes and widens the operands to `WIDTH` bits. Operands and results move through a valid/ready handshake, and every result is registered and carries status flags. Multiply runs as a multi-cycle shift-add, so the datapath needs only one adder; the block sits between an operand-issue stage and a result consumer that can apply backpressure.

---
 rtl/alu_pkg.sv | 46 ++++
 rtl/alu_seq_n_if.sv | 35 +++
 rtl/alu_mul_seq.sv | 76 +++++++
 rtl/alu_seq_n.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the sequential ALU slice:
//   - opcode encodings OP_ADD .. OP_MUL (4-bit CTRL field)
//   - FSM state encoding (IDLE / EXEC / DONE)
//   - status flag bit order inside the internal flag vector, plus a packer
// ---------------------------------------------------------------------------
package alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_NOT  = 4'b0100;
    localparam logic [3:0] OP_NAND = 4'b0101;
    localparam logic [3:0] OP_NOR  = 4'b0110;
    localparam logic [3:0] OP_XOR  = 4'b0111;
    localparam logic [3:0] OP_XNOR = 4'b1000;
    localparam logic [3:0] OP_MUL  = 4'b1001;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int FLAG_CARRY = 0;
    localparam int FLAG_OVF   = 1;
    localparam int FLAG_ZERO  = 2;
    localparam int FLAG_ERR   = 3;
    localparam int FLAG_W     = 4;

    typedef logic [FLAG_W-1:0] flags_t;

    function automatic flags_t pack_flags(input logic carry, input logic ovf,
                                          input logic zero, input logic err);
        flags_t f;
        f             = '0;
        f[FLAG_CARRY] = carry;
        f[FLAG_OVF]   = ovf;
        f[FLAG_ZERO]  = zero;
        f[FLAG_ERR]   = err;
        return f;
    endfunction

endpackage

// File: rtl/alu_seq_n_if.sv
// ---------------------------------------------------------------------------
// alu_seq_n_if
// Operand-issue and result handshake bundle of alu_seq_n.
//   in_valid/in_ready : operand handshake, carries A, B, CTRL
//   out_valid/out_ready: result handshake, carries Y, carry, ovf, zero, err
// Modports:
//   master : the issuing/consuming side (testbench or upstream stage)
//   slave  : the ALU itself
// ---------------------------------------------------------------------------
interface alu_seq_n_if #(
    parameter int WIDTH = 4
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     A;
    logic [WIDTH-1:0]     B;
    logic [3:0]           CTRL;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   Y;
    logic                 carry;
    logic                 ovf;
    logic                 zero;
    logic                 err;

    modport master (
        output in_valid, A, B, CTRL, out_ready,
        input  in_ready, out_valid, Y, carry, ovf, zero, err
    );

    modport slave (
        input  in_valid, A, B, CTRL, out_ready,
        output in_ready, out_valid, Y, carry, ovf, zero, err
    );
endinterface

// File: rtl/alu_mul_seq.sv
// ---------------------------------------------------------------------------
// alu_mul_seq
// Unsigned shift-add multiplier, one partial-product step per clock.
// Ports:
//   clk, rst : clock, synchronous active-high reset (aborts a running multiply)
//   start    : load a/b and begin; must only pulse while idle
//   a, b     : WIDTH-bit unsigned operands
//   done     : one-cycle pulse, product valid in that cycle
//   product  : 2*WIDTH-bit result
// A start edge loads the operands; the following WIDTH edges each perform one
// iteration, and done is raised together with the final iteration.
// ---------------------------------------------------------------------------
module alu_mul_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [2*WIDTH-1:0] mcand_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               busy_q;
    logic               done_q;

    // Control: iteration counter and busy/done; cleared by rst so that an
    // aborted multiply can never produce a done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            done_q <= 1'b0;
            if (start) begin
                busy_q <= 1'b1;
                cnt_q  <= CNT_W'(WIDTH);
            end else if (busy_q) begin
                cnt_q <= cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end
            end
        end
    end

    // Datapath: multiplicand walks left, multiplier walks right, and the
    // accumulator adds the multiplicand whenever the multiplier LSB is set.
    always_ff @(posedge clk) begin
        if (start) begin
            mcand_q  <= {{WIDTH{1'b0}}, a};
            mplier_q <= b;
            acc_q    <= '0;
        end else if (busy_q) begin
            if (mplier_q[0]) begin
                acc_q <= acc_q + mcand_q;
            end
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
        end
    end

    assign done    = done_q;
    assign product = acc_q;

endmodule

// File: rtl/alu_seq_n.sv
// ---------------------------------------------------------------------------
// alu_seq_n
// Sequential WIDTH-bit ALU with valid/ready handshakes on both sides.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : alu_seq_n_if.slave
//            in_valid/in_ready + A, B, CTRL   (operand side)
//            out_valid/out_ready + Y, carry, ovf, zero, err (result side)
// Flow: IDLE accepts and captures operands, EXEC computes (one cycle to
// register logic/add results, or the multi-cycle multiplier for OP_MUL),
// DONE holds the registered result until the consumer takes it.
// Latency accept->out_valid: 2 cycles, or WIDTH+2 for multiply.
// ---------------------------------------------------------------------------
module alu_seq_n
    import alu_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic           clk,
    input  logic           rst,
    alu_seq_n_if.slave     bus
);
    state_t               state_q;
    logic                 exec_phase_q;
    logic [3:0]           op_q;
    logic [WIDTH-1:0]     a_q;
    logic [WIDTH-1:0]     b_q;
    logic [2*WIDTH-1:0]   y_q;
    flags_t               flags_q;

    logic                 is_sub;
    logic [WIDTH-1:0]     b_eff;
    logic [WIDTH:0]       sum_full;
    logic signed [WIDTH-1:0] a_sv;
    logic signed [WIDTH-1:0] b_sv;
    logic signed [WIDTH-1:0] s_sv;

    logic [2*WIDTH-1:0]   res_y;
    logic                 res_carry;
    logic                 res_ovf;
    logic                 res_err;
    flags_t               res_flags;

    logic                 mul_start;
    logic                 mul_done;
    logic [2*WIDTH-1:0]   mul_prod;

    // Single add unit shared by add and sub: sub feeds ~B with carry-in 1,
    // so the carry-out doubles as the no-borrow (A >= B) flag.
    always_comb begin
        is_sub   = (op_q == OP_SUB);
        b_eff    = is_sub ? ~b_q : b_q;
        sum_full = {1'b0, a_q} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};
        a_sv     = signed'(a_q);
        b_sv     = signed'(b_q);
        s_sv     = signed'(sum_full[WIDTH-1:0]);
    end

    always_comb begin
        res_y     = '0;
        res_carry = 1'b0;
        res_ovf   = 1'b0;
        res_err   = 1'b0;
        case (op_q)
            OP_ADD: begin
                res_y[WIDTH:0] = sum_full;
                res_carry      = sum_full[WIDTH];
                res_ovf        = ((a_sv < 0) == (b_sv < 0)) && ((s_sv < 0) != (a_sv < 0));
            end
            OP_SUB: begin
                res_y[WIDTH:0] = sum_full;
                res_carry      = sum_full[WIDTH];
                res_ovf        = ((a_sv < 0) != (b_sv < 0)) && ((s_sv < 0) != (a_sv < 0));
            end
            OP_AND:  res_y[WIDTH-1:0] = a_q & b_q;
            OP_OR:   res_y[WIDTH-1:0] = a_q | b_q;
            OP_NOT:  res_y[WIDTH-1:0] = ~a_q;
            OP_NAND: res_y[WIDTH-1:0] = ~(a_q & b_q);
            OP_NOR:  res_y[WIDTH-1:0] = ~(a_q | b_q);
            OP_XOR:  res_y[WIDTH-1:0] = a_q ^ b_q;
            OP_XNOR: res_y[WIDTH-1:0] = ~(a_q ^ b_q);
            OP_MUL:  res_y            = mul_prod;
            default: res_err          = 1'b1;
        endcase
        res_flags = pack_flags(res_carry, res_ovf, (res_y == '0), res_err);
    end

    // The multiplier is kicked once, in the first EXEC cycle.
    assign mul_start = (state_q == ST_EXEC) && !exec_phase_q && (op_q == OP_MUL);

    alu_mul_seq #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .a       (a_q),
        .b       (b_q),
        .done    (mul_done),
        .product (mul_prod)
    );

    // FSM with operand and result registers. exec_phase_q splits EXEC into
    // an entry cycle (register logic/add result, or start the multiplier)
    // and the following cycle(s) that hand over to DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            exec_phase_q <= 1'b0;
            y_q          <= '0;
            flags_q      <= pack_flags(1'b0, 1'b0, 1'b1, 1'b0);
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        a_q          <= bus.A;
                        b_q          <= bus.B;
                        op_q         <= bus.CTRL;
                        exec_phase_q <= 1'b0;
                        state_q      <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    exec_phase_q <= 1'b1;
                    if (op_q == OP_MUL) begin
                        if (mul_done) begin
                            y_q     <= res_y;
                            flags_q <= res_flags;
                            state_q <= ST_DONE;
                        end
                    end else if (!exec_phase_q) begin
                        y_q     <= res_y;
                        flags_q <= res_flags;
                    end else begin
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state_q == ST_IDLE) && !rst;
    assign bus.out_valid = (state_q == ST_DONE);
    assign bus.Y         = y_q;
    assign bus.carry     = flags_q[FLAG_CARRY];
    assign bus.ovf       = flags_q[FLAG_OVF];
    assign bus.zero      = flags_q[FLAG_ZERO];
    assign bus.err       = flags_q[FLAG_ERR];

endmodule
